// File: rtl/fifo_pkg.sv
// Shared FIFO-family package: clog2 helper, legal parameter ranges and error codes.
// Used by sync_fifo_param (optional SYNC_FIFO_PARAM_HWM_EN build) and the async FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_MIN_DEPTH = 2;
    localparam int unsigned FIFO_MAX_DEPTH = 1024;
    localparam int unsigned FIFO_MIN_WIDTH = 1;
    localparam int unsigned FIFO_MAX_WIDTH = 512;

    localparam logic [1:0] FIFO_ERR_NONE = 2'b00;
    localparam logic [1:0] FIFO_ERR_OVF  = 2'b01;
    localparam logic [1:0] FIFO_ERR_UDF  = 2'b10;
    localparam logic [1:0] FIFO_ERR_BOTH = 2'b11;

    // Elaboration-time ceil(log2(v)); returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// W x D simple dual-port RAM: synchronous write, combinational read (FWFT=1)
// or registered read with reset-cleared output (FWFT=0).
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int W    = 8,
    parameter int D    = 5,
    parameter int AW   = 3,
    parameter int FWFT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_comb_rd
            // Read strobe and reset have no role in the show-ahead path.
            logic unused_ok;
            assign unused_ok = &{1'b0, re, reset_n};
            assign rdata = mem[raddr];
        end else begin : g_reg_rd
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO for any depth 2..1024 with thresholds, fill count, sticky errors.
// Define SYNC_FIFO_PARAM_HWM_EN to add the hwm (peak occupancy) output.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int W         = 8,
    parameter int D         = 5,
    parameter int AFULL_TH  = D - 1,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 1,
    parameter int CW        = clog2(D + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          full,
    output logic          afull,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          aempty,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          udf,
    input  logic          clr_err
`ifdef SYNC_FIFO_PARAM_HWM_EN
   ,output logic [CW-1:0] hwm
`endif
);

    localparam int PW = clog2(D);
    localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);

    generate
        if (D < FIFO_MIN_DEPTH || D > FIFO_MAX_DEPTH) begin : g_bad_depth
            $error("sync_fifo_param: D out of range");
        end
        if (W < FIFO_MIN_WIDTH || W > FIFO_MAX_WIDTH) begin : g_bad_width
            $error("sync_fifo_param: W out of range");
        end
        if (AFULL_TH < 1 || AFULL_TH > D || AEMPTY_TH < 0 || AEMPTY_TH > D - 1) begin : g_bad_th
            $error("sync_fifo_param: threshold out of range");
        end
    endgenerate

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wacc;
    logic          racc;
    logic          ram_we;
    logic          ram_re;

    // Acceptance uses the pre-edge flags; flush cancels both operations.
    assign wacc   = wr_en & ~full;
    assign racc   = rd_en & ~empty;
    assign ram_we = wacc & ~flush;
    assign ram_re = racc & ~flush;

    assign full   = (count == CW'(D));
    assign empty  = (count == '0);
    assign afull  = (count >= CW'(AFULL_TH));
    assign aempty = (count <= CW'(AEMPTY_TH));

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wacc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (racc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(wacc) - CW'(racc);
        end
    end

    // Sticky errors survive flush; a new error outranks clr_err.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (!flush && wr_en && full) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (!flush && rd_en && empty) begin
                udf <= 1'b1;
            end else if (clr_err) begin
                udf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_valid_fwft
            assign rd_valid = ~empty;
        end else begin : g_valid_reg
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_valid <= 1'b0;
                end else if (flush) begin
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= racc;
                end
            end
        end
    endgenerate

`ifdef SYNC_FIFO_PARAM_HWM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hwm <= '0;
        end else if (flush) begin
            hwm <= '0;
        end else if (count > hwm) begin
            hwm <= count;
        end
    end
`endif

    fifo_dpram #(
        .W    (W),
        .D    (D),
        .AW   (PW),
        .FWFT (FWFT)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (wr_ptr),
        .wdata   (wr_data),
        .re      (ram_re),
        .raddr   (rd_ptr),
        .rdata   (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: show-ahead and registered-read instances driven together,
// checked against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset_n, flush, wr_en, rd_en, clr_err;
    logic [W-1:0] wr_data;

    logic a_full, a_afull, a_rd_valid, a_empty, a_aempty, a_ovf, a_udf;
    logic [W-1:0] a_rd_data;
    logic [CW-1:0] a_count;
    logic b_full, b_afull, b_rd_valid, b_empty, b_aempty, b_ovf, b_udf;
    logic [W-1:0] b_rd_data;
    logic [CW-1:0] b_count;
`ifdef SYNC_FIFO_PARAM_HWM_EN
    logic [CW-1:0] a_hwm, b_hwm;
`endif

    always #5 clk = ~clk;

    sync_fifo_param #(.W(W), .D(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(a_full), .afull(a_afull), .rd_en(rd_en), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .empty(a_empty), .aempty(a_aempty), .count(a_count),
        .ovf(a_ovf), .udf(a_udf), .clr_err(clr_err)
`ifdef SYNC_FIFO_PARAM_HWM_EN
       ,.hwm(a_hwm)
`endif
    );

    sync_fifo_param #(.W(W), .D(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_reg (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(b_full), .afull(b_afull), .rd_en(rd_en), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .empty(b_empty), .aempty(b_aempty), .count(b_count),
        .ovf(b_ovf), .udf(b_udf), .clr_err(clr_err)
`ifdef SYNC_FIFO_PARAM_HWM_EN
       ,.hwm(b_hwm)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] q[$];
    bit           m_ovf, m_udf, m_rv;
    logic [W-1:0] m_hold;
    int           m_hwm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_dut(input string p, input logic [CW-1:0] cnt, input logic fl,
                           input logic af, input logic em, input logic ae,
                           input logic ov, input logic ud);
        int n;
        n = q.size();
        chk({p, "count"},  32'(cnt), 32'(n));
        chk({p, "full"},   32'(fl),  32'(n == D));
        chk({p, "afull"},  32'(af),  32'(n >= AF));
        chk({p, "empty"},  32'(em),  32'(n == 0));
        chk({p, "aempty"}, 32'(ae),  32'(n <= AE));
        chk({p, "ovf"},    32'(ov),  32'(m_ovf));
        chk({p, "udf"},    32'(ud),  32'(m_udf));
    endtask

    task automatic check_all();
        chk_dut("a_", a_count, a_full, a_afull, a_empty, a_aempty, a_ovf, a_udf);
        chk_dut("b_", b_count, b_full, b_afull, b_empty, b_aempty, b_ovf, b_udf);
        chk("a_rd_valid", 32'(a_rd_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("a_rd_data", 32'(a_rd_data), 32'(q[0]));
        end
        chk("b_rd_valid", 32'(b_rd_valid), 32'(m_rv));
        chk("b_rd_data",  32'(b_rd_data),  32'(m_hold));
`ifdef SYNC_FIFO_PARAM_HWM_EN
        chk("a_hwm", 32'(a_hwm), 32'(m_hwm));
        chk("b_hwm", 32'(b_hwm), 32'(m_hwm));
`endif
    endtask

    // One clock: drive, advance the model by the FIFO rules, sample 1ns after the edge.
    task automatic cycle(input bit we, input bit re, input bit fl, input bit ce,
                         input logic [W-1:0] wd);
        int n;
        n       = q.size();
        wr_en   = we;
        rd_en   = re;
        flush   = fl;
        clr_err = ce;
        wr_data = wd;
        if (fl) begin
            m_hwm = 0;
            q.delete();
            m_rv = 1'b0;
            if (ce) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            if (n > m_hwm) m_hwm = n;
            if (we && n == D) m_ovf = 1'b1;
            else if (ce)      m_ovf = 1'b0;
            if (re && n == 0) m_udf = 1'b1;
            else if (ce)      m_udf = 1'b0;
            m_rv = re && n > 0;
            if (m_rv) m_hold = q.pop_front();
            if (we && n < D) q.push_back(wd);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_rv   = 1'b0;
        m_hold = '0;
        m_hwm  = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wr_data = '0;
        model_reset();
        #12;
        check_all();
        reset_n = 1'b1;

        // Fill 0x11..0x15 then drain in order
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 8'h11 + 8'(i));
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 8'h00);

        // Three streaming passes of 7 words, wrapping the pointers
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 7; i++) cycle(1, i >= 3, 0, 0, 8'(8'h40 + 16 * p + i));
            for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 8'h00);
        end

        // Full with both requests: read wins, 0xEE dropped; empty with both: write wins
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 8'h21 + 8'(i));
        cycle(1, 1, 0, 0, 8'hEE);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 8'h77);
        cycle(0, 1, 0, 0, 8'h00);

        // Registered-read latency
        cycle(1, 0, 0, 0, 8'hA5);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h00);

        // Flush with write at count 3 keeps errors, then clr_err
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 8'h31 + 8'(i));
        cycle(1, 0, 1, 0, 8'h99);
        cycle(0, 0, 0, 1, 8'h00);

        // Peak occupancy 4, then flush
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'h51 + 8'(i));
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h00);
        cycle(0, 0, 1, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h00);

        // Randomised traffic with shifting write/read bias
        for (int i = 0; i < 600; i++) begin
            int unsigned wbias, rbias;
            bit fl, we, re, ce;
            wbias = ((i / 50) % 2 == 0) ? 75 : 30;
            rbias = 100 - wbias;
            fl = ($urandom_range(0, 39) == 0);
            we = !fl && ($urandom_range(0, 99) < wbias);
            re = !fl && ($urandom_range(0, 99) < rbias);
            ce = ($urandom_range(0, 15) == 0);
            cycle(we, re, fl, ce, 8'($urandom));
        end

        // Asynchronous reset mid-fill with sticky error set
        cycle(0, 0, 1, 1, 8'h00);
        cycle(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 8'h61 + 8'(i));
        cycle(0, 1, 0, 0, 8'h00);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 8'h71 + 8'(i));
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
